// File: rtl/hht_row_sched_if.sv
// hht_row_sched_if -- bundle of every non-clock signal of hht_row_sched.
//   Walk control : start, num_rows, row_base, col_base, val_base, vec_base
//   Memory port 1: addr1 out, dataIn1 in (row pointers and column indices)
//   Memory port 2: addr2 out, dataIn2 in (matrix values and vector elements)
//   Output stream: out_valid/out_ready handshake with out_val, out_vec,
//                  out_row, out_last
//   Status       : row_done, busy, done, err
// The master modport is the scheduler. The slave modport is whoever supplies
// the memories, drives start and consumes the stream.
interface hht_row_sched_if #(
  parameter int DATA_W = 32
);
  logic              start;
  logic [DATA_W-1:0] num_rows;
  logic [DATA_W-1:0] row_base;
  logic [DATA_W-1:0] col_base;
  logic [DATA_W-1:0] val_base;
  logic [DATA_W-1:0] vec_base;
  logic [DATA_W-1:0] addr1;
  logic [DATA_W-1:0] dataIn1;
  logic [DATA_W-1:0] addr2;
  logic [DATA_W-1:0] dataIn2;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_val;
  logic [DATA_W-1:0] out_vec;
  logic [DATA_W-1:0] out_row;
  logic              out_last;
  logic              row_done;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    input  start, num_rows, row_base, col_base, val_base, vec_base,
    input  dataIn1, dataIn2, out_ready,
    output addr1, addr2, out_valid, out_val, out_vec, out_row, out_last,
    output row_done, busy, done, err
  );

  modport slave (
    output start, num_rows, row_base, col_base, val_base, vec_base,
    output dataIn1, dataIn2, out_ready,
    input  addr1, addr2, out_valid, out_val, out_vec, out_row, out_last,
    input  row_done, busy, done, err
  );
endinterface

// File: rtl/hht_row_sched.sv
// hht_row_sched -- walks a CSR sparse matrix row by row. For every nonzero it
// fetches the column index and value, then the matching dense-vector element.
// It streams {val, vec, row, last} through a small FIFO.
//   Clk : clock, rising edge
//   Rst : asynchronous active-high reset
//   bus : hht_row_sched_if.master (walk control, two combinational-read
//         memory ports, output stream, status)
// Memory data is combinational from the address. Each address is therefore
// driven combinationally during the state that needs it, and the returned
// data is captured at the edge that closes that state. Between reads the
// ports replay the last address that was driven.
module hht_row_sched #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input logic             Clk,
  input logic             Rst,
  hht_row_sched_if.master bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);
  localparam logic [DATA_W-1:0] ONE      = DATA_W'(1);

  typedef enum logic [2:0] {IDLE, ROWPTR, COL, VEC, ROWEND, FIN} state_t;

  typedef struct packed {
    logic [DATA_W-1:0] val;
    logic [DATA_W-1:0] vec;
    logic [DATA_W-1:0] row;
    logic              last;
  } entry_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] num_rows_q, num_rows_d;
  logic [DATA_W-1:0] row_base_q, row_base_d, col_base_q, col_base_d;
  logic [DATA_W-1:0] val_base_q, val_base_d, vec_base_q, vec_base_d;
  logic [DATA_W-1:0] row_q, row_d, k_q, k_d;
  logic [DATA_W-1:0] ptr_lo_q, ptr_lo_d, ptr_hi_q, ptr_hi_d;
  logic [DATA_W-1:0] col_q, col_d, val_q, val_d;
  logic [DATA_W-1:0] addr1_q, addr1_d, addr2_q, addr2_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic              row_done_q, row_done_d, err_q, err_d;
  logic [DATA_W-1:0] k_inc, row_inc;
  logic              push;
  entry_t            push_entry;

  entry_t            mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  entry_t            head_q, head_d;
  logic              out_valid_q, out_valid_d;
  logic              pop, fifo_full, stays_empty;

  assign k_inc   = k_q + ONE;
  assign row_inc = row_q + ONE;

  // ---------------- walk FSM ----------------
  always_comb begin
    state_d    = state_q;
    num_rows_d = num_rows_q;
    row_base_d = row_base_q;
    col_base_d = col_base_q;
    val_base_d = val_base_q;
    vec_base_d = vec_base_q;
    row_d      = row_q;
    k_d        = k_q;
    ptr_lo_d   = ptr_lo_q;
    ptr_hi_d   = ptr_hi_q;
    col_d      = col_q;
    val_d      = val_q;
    addr1_d    = addr1_q;
    addr2_d    = addr2_q;
    busy_d     = busy_q;
    err_d      = err_q;
    done_d     = 1'b0;
    row_done_d = 1'b0;
    push       = 1'b0;
    // The vector element arrives on port 2 during VEC and goes straight in.
    push_entry = '{val: val_q, vec: bus.dataIn2, row: row_q, last: (k_inc == ptr_hi_q)};
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          num_rows_d = bus.num_rows;
          row_base_d = bus.row_base;
          col_base_d = bus.col_base;
          val_base_d = bus.val_base;
          vec_base_d = bus.vec_base;
          addr1_d    = bus.row_base;
          ptr_lo_d   = bus.dataIn1;
          row_d      = '0;
          busy_d     = 1'b1;
          err_d      = 1'b0;
          state_d    = (bus.num_rows == '0) ? FIN : ROWPTR;
        end
      end
      ROWPTR: begin
        addr1_d  = row_base_q + row_q + ONE;
        ptr_hi_d = bus.dataIn1;
        if (bus.dataIn1 < ptr_lo_q) begin
          err_d   = 1'b1;
          state_d = FIN;
        end else if (bus.dataIn1 == ptr_lo_q) begin
          state_d = ROWEND;
        end else begin
          k_d     = ptr_lo_q;
          state_d = COL;
        end
      end
      COL: begin
        addr1_d = col_base_q + k_q;
        addr2_d = val_base_q + k_q;
        col_d   = bus.dataIn1;
        val_d   = bus.dataIn2;
        state_d = VEC;
      end
      VEC: begin
        // While the FIFO is full, stay here and keep the vector address on port 2.
        addr2_d = vec_base_q + col_q;
        if (!fifo_full) begin
          push    = 1'b1;
          k_d     = k_inc;
          state_d = push_entry.last ? ROWEND : COL;
        end
      end
      ROWEND: begin
        row_done_d = 1'b1;
        ptr_lo_d   = ptr_hi_q;
        row_d      = row_inc;
        state_d    = (row_inc == num_rows_q) ? FIN : ROWPTR;
      end
      FIN: begin
        if (count_q == '0) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------- output FIFO ----------------
  // head_q always mirrors the oldest entry. count includes that entry, so the
  // FIFO is empty only once the consumer has taken the last beat.
  assign fifo_full   = (count_q == FULL_CNT);
  assign pop         = out_valid_q && bus.out_ready;
  assign stays_empty = pop ? (count_q == CNT_ONE) : (count_q == '0);

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_ONE;
    end else if (!push && pop) begin
      count_d = count_q - CNT_ONE;
    end
    out_valid_d = (count_d != '0);
    head_d      = head_q;
    if (count_d != '0) begin
      // If no older entry survives this edge, the entry being pushed becomes
      // the head directly, because it is not in the array yet.
      head_d = stays_empty ? push_entry : mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge Clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= push_entry;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q     <= IDLE;
      num_rows_q  <= '0;
      row_base_q  <= '0;
      col_base_q  <= '0;
      val_base_q  <= '0;
      vec_base_q  <= '0;
      row_q       <= '0;
      k_q         <= '0;
      ptr_lo_q    <= '0;
      ptr_hi_q    <= '0;
      col_q       <= '0;
      val_q       <= '0;
      addr1_q     <= '0;
      addr2_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      row_done_q  <= 1'b0;
      err_q       <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      head_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      num_rows_q  <= num_rows_d;
      row_base_q  <= row_base_d;
      col_base_q  <= col_base_d;
      val_base_q  <= val_base_d;
      vec_base_q  <= vec_base_d;
      row_q       <= row_d;
      k_q         <= k_d;
      ptr_lo_q    <= ptr_lo_d;
      ptr_hi_q    <= ptr_hi_d;
      col_q       <= col_d;
      val_q       <= val_d;
      addr1_q     <= addr1_d;
      addr2_q     <= addr2_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      row_done_q  <= row_done_d;
      err_q       <= err_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      head_q      <= head_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Masking with Rst keeps the addresses at zero during reset, even if start
  // is held high while reset is asserted.
  assign bus.addr1     = Rst ? '0 : addr1_d;
  assign bus.addr2     = Rst ? '0 : addr2_d;
  assign bus.out_valid = out_valid_q;
  assign bus.out_val   = head_q.val;
  assign bus.out_vec   = head_q.vec;
  assign bus.out_row   = head_q.row;
  assign bus.out_last  = head_q.last;
  assign bus.row_done  = row_done_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_hht_row_sched.sv
// tb_hht_row_sched -- directed bench for hht_row_sched. A 16K-word array acts
// as both combinational memories. A negedge monitor records accepted beats,
// row_done pulses and done pulses. Start is raised 1 time unit after a rising
// edge, and latencies are counted in rising edges from that point.
module tb_hht_row_sched;
  localparam int DW        = 32;
  localparam int MEM_WORDS = 16384;

  typedef struct packed {
    logic [DW-1:0] val;
    logic [DW-1:0] vec;
    logic [DW-1:0] row;
    logic          last;
  } beat_t;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  always #5 Clk = ~Clk;

  hht_row_sched_if #(.DATA_W(DW)) bus ();

  hht_row_sched #(.DATA_W(DW), .FIFO_DEPTH(4)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  logic [DW-1:0] mem [MEM_WORDS];

  always_comb begin
    bus.dataIn1 = (bus.addr1 < DW'(MEM_WORDS)) ? mem[bus.addr1[13:0]] : '0;
    bus.dataIn2 = (bus.addr2 < DW'(MEM_WORDS)) ? mem[bus.addr2[13:0]] : '0;
  end

  int    checks = 0;
  int    errors = 0;
  beat_t beats[$];
  int    row_done_cnt = 0;
  int    done_cnt = 0;

  always @(negedge Clk) begin
    if (!Rst) begin
      if (bus.out_valid && bus.out_ready) begin
        beats.push_back({bus.out_val, bus.out_vec, bus.out_row, bus.out_last});
        $display("beat row=%0d val=%0d vec=%0d last=%0b", bus.out_row, bus.out_val, bus.out_vec, bus.out_last);
      end
      if (bus.row_done) row_done_cnt++;
      if (bus.done) done_cnt++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic load_row0();
    mem[14610] = 0;  mem[14611] = 4;
    mem[1410] = 0;   mem[1411] = 8;   mem[1412] = 9;   mem[1413] = 14;
    mem[90] = 30;    mem[91] = 25;    mem[92] = 89;    mem[93] = 98;
    mem[2] = 6;      mem[10] = 96;    mem[11] = 71;    mem[16] = 62;
  endtask

  // Raises start for one edge, then waits up to budget edges for done.
  task automatic run_walk(input logic [DW-1:0] nr, input logic [DW-1:0] rb, input logic [DW-1:0] cb,
                          input logic [DW-1:0] vb, input logic [DW-1:0] xb, input int budget,
                          output int t_valid, output int t_done);
    @(posedge Clk); #1;
    beats.delete();
    row_done_cnt = 0;
    done_cnt = 0;
    t_valid = -1;
    t_done = -1;
    bus.num_rows = nr; bus.row_base = rb; bus.col_base = cb;
    bus.val_base = vb; bus.vec_base = xb;
    bus.start = 1'b1;
    for (int n = 1; n <= budget; n++) begin
      @(posedge Clk); #1;
      bus.start = 1'b0;
      @(negedge Clk);
      if (t_valid < 0 && bus.out_valid) t_valid = n;
      if (bus.done) begin
        t_done = n;
        break;
      end
    end
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    bus.start = 1'b0; bus.out_ready = 1'b1; bus.num_rows = '0;
    bus.row_base = '0; bus.col_base = '0; bus.val_base = '0; bus.vec_base = '0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    checks++;
    if ({bus.out_valid, bus.row_done, bus.busy, bus.done, bus.err, bus.out_last} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b want 000000", {bus.out_valid, bus.row_done, bus.busy, bus.done, bus.err, bus.out_last});
    end
    checks++;
    if ({bus.addr1, bus.addr2} !== '0) begin
      errors++;
      $display("FAIL reset_addr: got addr1=%0d addr2=%0d want 0 0", bus.addr1, bus.addr2);
    end
    checks++;
    if ({bus.out_val, bus.out_vec, bus.out_row} !== '0) begin
      errors++;
      $display("FAIL reset_out: got val=%0d vec=%0d row=%0d want 0 0 0", bus.out_val, bus.out_vec, bus.out_row);
    end
    @(posedge Clk); #1;
    Rst = 1'b0;
  endtask

  task automatic test_row0();
    beat_t exp [4];
    int tv, td;
    exp[0] = {32'd30, 32'd6,  32'd0, 1'b0};
    exp[1] = {32'd25, 32'd96, 32'd0, 1'b0};
    exp[2] = {32'd89, 32'd71, 32'd0, 1'b0};
    exp[3] = {32'd98, 32'd62, 32'd0, 1'b1};
    load_row0();
    run_walk(1, 14610, 1410, 90, 2, 100, tv, td);
    checks++;
    if (tv !== 4) begin errors++; $display("FAIL row0_first_valid: got %0d cycles want 4", tv); end
    checks++;
    if (td !== 12) begin errors++; $display("FAIL row0_done_time: got %0d cycles want 12", td); end
    checks++;
    if (beats.size() !== 4) begin errors++; $display("FAIL row0_beat_count: got %0d want 4", beats.size()); end
    for (int i = 0; i < 4 && i < beats.size(); i++) begin
      checks++;
      if (beats[i] !== exp[i]) begin
        errors++;
        $display("FAIL row0_beat%0d: got val=%0d vec=%0d row=%0d last=%0b want val=%0d vec=%0d row=%0d last=%0b",
                 i, beats[i].val, beats[i].vec, beats[i].row, beats[i].last, exp[i].val, exp[i].vec, exp[i].row, exp[i].last);
      end
    end
    checks++;
    if (row_done_cnt !== 1) begin errors++; $display("FAIL row0_row_done: got %0d pulses want 1", row_done_cnt); end
    checks++;
    if (done_cnt !== 1 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL row0_end: got done=%0d busy=%0b want 1 0", done_cnt, bus.busy);
    end
  endtask

  task automatic test_empty_row();
    beat_t exp [2];
    int tv, td;
    exp[0] = {32'd11, 32'd101, 32'd1, 1'b0};
    exp[1] = {32'd22, 32'd103, 32'd1, 1'b1};
    mem[100] = 4; mem[101] = 4; mem[102] = 6;
    mem[204] = 1; mem[205] = 3;
    mem[304] = 11; mem[305] = 22;
    mem[401] = 101; mem[403] = 103;
    run_walk(2, 100, 200, 300, 400, 100, tv, td);
    checks++;
    if (beats.size() !== 2) begin errors++; $display("FAIL empty_beat_count: got %0d want 2", beats.size()); end
    for (int i = 0; i < 2 && i < beats.size(); i++) begin
      checks++;
      if (beats[i] !== exp[i]) begin
        errors++;
        $display("FAIL empty_beat%0d: got val=%0d vec=%0d row=%0d last=%0b want val=%0d vec=%0d row=%0d last=%0b",
                 i, beats[i].val, beats[i].vec, beats[i].row, beats[i].last, exp[i].val, exp[i].vec, exp[i].row, exp[i].last);
      end
    end
    checks++;
    if (row_done_cnt !== 2) begin errors++; $display("FAIL empty_row_done: got %0d pulses want 2", row_done_cnt); end
    checks++;
    if (td < 0 || done_cnt !== 1) begin errors++; $display("FAIL empty_done: got t=%0d count=%0d want done once", td, done_cnt); end
  endtask

  task automatic test_backpressure();
    int tv, td;
    for (int i = 0; i < 6; i++) begin
      mem[600 + i] = i;
      mem[700 + i] = 41 + i;
      mem[800 + i] = 51 + i;
    end
    mem[500] = 0; mem[501] = 6;
    bus.out_ready = 1'b0;
    run_walk(1, 500, 600, 700, 800, 20, tv, td);
    checks++;
    if (td !== -1 || bus.busy !== 1'b1) begin
      errors++; $display("FAIL bp_stalled: got done_at=%0d busy=%0b want -1 1", td, bus.busy);
    end
    checks++;
    if (bus.addr2 !== 32'd804) begin errors++; $display("FAIL bp_addr2: got %0d want 804", bus.addr2); end
    checks++;
    if ({bus.out_valid, bus.out_val, bus.out_vec, bus.out_row} !== {1'b1, 32'd41, 32'd51, 32'd0}) begin
      errors++; $display("FAIL bp_head: got valid=%0b val=%0d vec=%0d row=%0d want 1 41 51 0",
                         bus.out_valid, bus.out_val, bus.out_vec, bus.out_row);
    end
    // A start while busy must not disturb the walk.
    @(posedge Clk); #1;
    bus.num_rows = 0; bus.start = 1'b1;
    @(posedge Clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    checks++;
    if (bus.addr2 !== 32'd804) begin errors++; $display("FAIL bp_addr2_frozen: got %0d want 804", bus.addr2); end
    @(posedge Clk); #1;
    bus.out_ready = 1'b1;
    td = -1;
    for (int n = 1; n <= 100; n++) begin
      @(negedge Clk);
      if (bus.done) begin td = n; break; end
    end
    @(posedge Clk);
    @(negedge Clk);
    checks++;
    if (td < 0 || done_cnt !== 1) begin errors++; $display("FAIL bp_done: got t=%0d count=%0d want done once", td, done_cnt); end
    checks++;
    if (beats.size() !== 6) begin errors++; $display("FAIL bp_beat_count: got %0d want 6", beats.size()); end
    for (int i = 0; i < 6 && i < beats.size(); i++) begin
      checks++;
      if (beats[i] !== {DW'(41 + i), DW'(51 + i), 32'd0, (i == 5)}) begin
        errors++;
        $display("FAIL bp_beat%0d: got val=%0d vec=%0d row=%0d last=%0b want val=%0d vec=%0d row=0 last=%0b",
                 i, beats[i].val, beats[i].vec, beats[i].row, beats[i].last, 41 + i, 51 + i, (i == 5));
      end
    end
  endtask

  task automatic test_malformed();
    int tv, td;
    mem[900] = 5; mem[901] = 3;
    run_walk(1, 900, 910, 920, 930, 50, tv, td);
    checks++;
    if (bus.err !== 1'b1) begin errors++; $display("FAIL bad_err: got %0b want 1", bus.err); end
    checks++;
    if (beats.size() !== 0) begin errors++; $display("FAIL bad_beats: got %0d want 0", beats.size()); end
    checks++;
    if (td !== 3 || done_cnt !== 1) begin errors++; $display("FAIL bad_done: got t=%0d count=%0d want 3 1", td, done_cnt); end
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL bad_busy: got %0b want 0", bus.busy); end
  endtask

  task automatic test_zero_rows();
    int tv, td;
    run_walk(0, 14610, 1410, 90, 2, 50, tv, td);
    checks++;
    if (td !== 2) begin errors++; $display("FAIL zero_done_time: got %0d cycles want 2", td); end
    checks++;
    if (beats.size() !== 0 || row_done_cnt !== 0) begin
      errors++; $display("FAIL zero_activity: got beats=%0d row_done=%0d want 0 0", beats.size(), row_done_cnt);
    end
    checks++;
    if (bus.err !== 1'b0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL zero_status: got err=%0b busy=%0b want 0 0", bus.err, bus.busy);
    end
  endtask

  task automatic test_mid_walk_reset();
    beat_t exp [4];
    int tv, td;
    exp[0] = {32'd30, 32'd6,  32'd0, 1'b0};
    exp[1] = {32'd25, 32'd96, 32'd0, 1'b0};
    exp[2] = {32'd89, 32'd71, 32'd0, 1'b0};
    exp[3] = {32'd98, 32'd62, 32'd0, 1'b1};
    @(posedge Clk); #1;
    bus.num_rows = 1; bus.row_base = 14610; bus.col_base = 1410;
    bus.val_base = 90; bus.vec_base = 2; bus.start = 1'b1;
    @(posedge Clk); #1;
    bus.start = 1'b0;
    @(posedge Clk);
    @(posedge Clk); #1;
    checks++;
    if (bus.busy !== 1'b1 || bus.addr2 !== 32'd2) begin
      errors++; $display("FAIL mid_pre_reset: got busy=%0b addr2=%0d want 1 2", bus.busy, bus.addr2);
    end
    Rst = 1'b1;
    #1;
    checks++;
    if ({bus.out_valid, bus.row_done, bus.busy, bus.done, bus.err, bus.out_last} !== 6'b0) begin
      errors++;
      $display("FAIL mid_reset_flags: got %b want 000000", {bus.out_valid, bus.row_done, bus.busy, bus.done, bus.err, bus.out_last});
    end
    checks++;
    if ({bus.addr1, bus.addr2, bus.out_val, bus.out_vec, bus.out_row} !== '0) begin
      errors++;
      $display("FAIL mid_reset_data: got addr1=%0d addr2=%0d val=%0d vec=%0d row=%0d want all 0",
               bus.addr1, bus.addr2, bus.out_val, bus.out_vec, bus.out_row);
    end
    @(posedge Clk);
    @(posedge Clk); #1;
    Rst = 1'b0;
    run_walk(1, 14610, 1410, 90, 2, 100, tv, td);
    checks++;
    if (tv !== 4 || td !== 12) begin errors++; $display("FAIL mid_replay_timing: got valid=%0d done=%0d want 4 12", tv, td); end
    checks++;
    if (beats.size() !== 4) begin errors++; $display("FAIL mid_replay_count: got %0d want 4", beats.size()); end
    for (int i = 0; i < 4 && i < beats.size(); i++) begin
      checks++;
      if (beats[i] !== exp[i]) begin
        errors++;
        $display("FAIL mid_replay_beat%0d: got val=%0d vec=%0d last=%0b want val=%0d vec=%0d last=%0b",
                 i, beats[i].val, beats[i].vec, beats[i].last, exp[i].val, exp[i].vec, exp[i].last);
      end
    end
  endtask

  initial begin
    for (int a = 0; a < MEM_WORDS; a++) mem[a] = '0;
    test_reset();
    test_row0();
    test_empty_row();
    test_backpressure();
    test_malformed();
    test_zero_rows();
    test_mid_walk_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/hht_row_sched.md
HHT_ROW_SCHED -- requirements
Module: hht_row_sched

Interface
REQ-001 The block SHALL have the following parameters, one per line: name, default, meaning.
- DATA_W, 32: memory data width and address width.
- FIFO_DEPTH, 4: output FIFO entries; a power of two, at least 2.

REQ-002 The block SHALL have the following ports, one per line: name, direction, width, meaning.
- Clk, in, 1: clock; all state changes on its rising edge.
- Rst, in, 1: reset, asynchronous, active-high.
- start, in, 1: begin a sparse-matrix walk; sampled only in IDLE.
- num_rows, in, DATA_W: number of CSR rows.
- row_base, in, DATA_W: base address of the row-pointer array.
- col_base, in, DATA_W: base address of the column-index array.
- val_base, in, DATA_W: base address of the nonzero-value array.
- vec_base, in, DATA_W: base address of the dense vector.
- addr1, out, DATA_W: port-1 read address.
- dataIn1, in, DATA_W: port-1 read data, combinational from addr1.
- addr2, out, DATA_W: port-2 read address.
- dataIn2, in, DATA_W: port-2 read data, combinational from addr2.
- out_valid, out, 1: FIFO head valid.
- out_ready, in, 1: consumer accepts the head.
- out_val, out, DATA_W: matrix value at the head.
- out_vec, out, DATA_W: vector element at the head.
- out_row, out, DATA_W: row index at the head.
- out_last, out, 1: head is the last nonzero of its row.
- row_done, out, 1: one-cycle pulse when fetch of a row completes, including empty rows.
- busy, out, 1: high from the start edge until done.
- done, out, 1: one-cycle pulse at walk end.
- err, out, 1: sticky malformed-row-pointer flag.

Function
REQ-003 Port 1 SHALL carry row-pointer and column-index reads; port 2 SHALL carry value and vector reads; data is captured at the same edge the address is driven.
REQ-004 The FSM SHALL have exactly the states IDLE, ROWPTR, COL, VEC, ROWEND and FIN.
REQ-005 IDLE, start=1: latch all bases and num_rows; drive addr1=row_base; capture ptr_lo; row=0; busy=1. If num_rows=0, go to FIN; otherwise go to ROWPTR.
REQ-006 ROWPTR: addr1=row_base+row+1; capture ptr_hi.
- ptr_hi<ptr_lo: set err and go to FIN.
- ptr_hi=ptr_lo: go to ROWEND.
- Otherwise: k=ptr_lo; go to COL.
REQ-007 COL: addr1=col_base+k and addr2=val_base+k in the same cycle; capture col and val; go to VEC.
REQ-008 VEC: addr2=vec_base+col.
- FIFO not full: push {val, dataIn2, row, last=(k+1==ptr_hi)}; k=k+1; go to ROWEND if last, else COL.
- FIFO full: hold all addresses and state.
REQ-009 ROWEND: pulse row_done; ptr_lo=ptr_hi; row=row+1. If row+1=num_rows, go to FIN; otherwise go to ROWPTR.
REQ-010 FIN: wait until the FIFO is empty, then pulse done, drop busy and go to IDLE.
REQ-011 When not reading, addr1 and addr2 SHALL hold their last values.
REQ-012 Address arithmetic SHALL be modulo 2^DATA_W, with no saturation.
REQ-013 FIFO ordering SHALL be first in, first out.
- A pop occurs when out_valid and out_ready are both high.
- A push is blocked when count=FIFO_DEPTH, even if a pop occurs in the same cycle.
- Simultaneous push and pop on a non-full FIFO leaves count unchanged.
- out_* outputs are registered from the head entry.
REQ-014 Timing: first out_valid SHALL rise 4 cycles after the start edge; steady-state throughput is 1 nonzero per 2 cycles with out_ready held high.
REQ-015 start while busy SHALL be ignored; err SHALL clear only on an accepted start or on reset.

Reset
REQ-016 Rst=1 SHALL force the following immediately, including mid-walk:
- state IDLE; FIFO empty;
- out_valid, row_done, busy, done and err all 0;
- addr1, addr2, out_val, out_vec, out_row and out_last all 0.
REQ-017 Data in flight at reset SHALL be discarded; the first start after reset release begins a fresh walk.

Verification
REQ-018 Row 0 fetch. Setup: row_base=14610, col_base=1410, val_base=90, vec_base=2, num_rows=1, row pointers {0,4}, columns {0,8,9,14}, values {30,25,89,98}, v[k] at address 2+k. Expected beats (val,vec): (30,6), (25,96), (89,71), (98,62); last=1 only on the fourth beat; one row_done; then done.
REQ-019 Empty row: row pointers {4,4,6}, num_rows=2. Required: row 0 produces no beat but does produce a row_done pulse; row 1 produces 2 beats with out_row=1.
REQ-020 Backpressure: out_ready=0 with a 6-nonzero row. Required: the FIFO holds 4 entries, addr2 stays frozen on the 5th vector address, and no beat is lost or duplicated after out_ready=1.
REQ-021 Malformed pointers: {5,3}. Required: err=1, no beats, done pulses, busy=0.
REQ-022 num_rows=0. Required: no memory beats; done pulses 2 cycles after start.
REQ-023 Mid-walk reset: Rst=1 during VEC. Required: all outputs are 0 at once; a new start replays row 0 identically to REQ-018.
